fft16_out_reorder: RTL and testbench

//   Sits directly downstream of the 16-point parallel FFT core and captures one full frame of its outputs.
//   The core presents the frame as Zr/Zi[0:N-1] in bit-reversed bin order.
//   The block reorders the frame into natural bin order and streams it one complex bin per cycle.

---
 rtl/fft16_out_reorder.sv | 152 +++++++++++++++
 tb/tb_fft16_out_reorder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_out_reorder.sv
// fft16_out_reorder: captures a bit-reversed FFT frame, streams natural order.
// Optional macro FFT_OUT_SCALE_EN: scale each component by 1/N on capture.
module fft16_out_reorder #(
  parameter  int DATA_WIDTH = 16,
  parameter  int N          = 16,
  localparam int LOG2N      = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH*N-1:0]      in_re,
  input  logic [DATA_WIDTH*N-1:0]      in_im,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_re,
  output logic signed [DATA_WIDTH-1:0] out_im,
  output logic [LOG2N-1:0]             out_idx,
  output logic                         out_last
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef logic signed [DATA_WIDTH-1:0] samp_t;

  logic [0:0]       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;

  samp_t buf_re_q [N];
  samp_t buf_re_d [N];
  samp_t buf_im_q [N];
  samp_t buf_im_d [N];

  logic             out_valid_q, out_valid_d;
  samp_t            out_re_q, out_re_d;
  samp_t            out_im_q, out_im_d;
  logic [LOG2N-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;

  logic beat;
  logic last_beat;
  logic capture;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] v
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // Round-half-up divide by N, done one bit wider so the bias cannot wrap.
  function automatic samp_t scale(input samp_t x);
`ifdef FFT_OUT_SCALE_EN
    logic signed [DATA_WIDTH:0] t;
    t = {x[DATA_WIDTH-1], x};
    t = t + (DATA_WIDTH+1)'(2 ** (LOG2N - 1));
    t = t >>> LOG2N;
    return DATA_WIDTH'(t);
`else
    return x;
`endif
  endfunction

  // Handshake: a frame is taken in IDLE, or on the transferring last bin.
  always_comb begin
    beat      = (state_q == S_STREAM) && out_ready && enable;
    last_beat = beat && (cnt_q == LAST);
    in_ready  = enable && ((state_q == S_IDLE) || last_beat);
    capture   = in_valid && in_ready;
  end

  // Frame buffer, FSM and bin counter next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_re_d = buf_re_q;
    buf_im_d = buf_im_q;
    if (capture) begin
      for (int k = 0; k < N; k++) begin
        buf_re_d[bitrev(LOG2N'(k))] =
          scale(in_re[k*DATA_WIDTH +: DATA_WIDTH]);
        buf_im_d[bitrev(LOG2N'(k))] =
          scale(in_im[k*DATA_WIDTH +: DATA_WIDTH]);
      end
      state_d = S_STREAM;
      cnt_d   = '0;
    end else if (last_beat) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output register is loaded from the next buffer so bin 0 follows capture.
  always_comb begin
    out_valid_d = (state_d == S_STREAM);
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    if (state_d == S_STREAM) begin
      out_re_d   = buf_re_d[cnt_d];
      out_im_d   = buf_im_d[cnt_d];
      out_idx_d  = cnt_d;
      out_last_d = (cnt_d == LAST);
    end
  end

  // State update; reset wins over enable, enable=0 freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        buf_re_q[k] <= '0;
        buf_im_q[k] <= '0;
      end
    end else if (enable) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      for (int k = 0; k < N; k++) begin
        buf_re_q[k] <= buf_re_d[k];
        buf_im_q[k] <= buf_im_d[k];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft16_out_reorder.sv
// tb_fft16_out_reorder: directed and random frames against a
// bin-order reference model of the output reorder block.
module tb_fft16_out_reorder;

  localparam int DW    = 16;
  localparam int N     = 16;
  localparam int LOG2N = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW*N-1:0]      in_re;
  logic [DW*N-1:0]      in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic [LOG2N-1:0]     out_idx;
  logic                 out_last;

  int tests  = 0;
  int failed = 0;

  bit m_stream;
  int m_ptr;
  bit m_zero;
  bit m_acc;
  bit checking;
  int m_re [N];
  int m_im [N];

  int obs_re [$];
  int obs_idx [$];

  int tbl [N] = '{0, 8, 4, 12, 2, 10, 6, 14,
                  1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  fft16_out_reorder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  // Reverse the LOG2N-bit binary representation of k arithmetically.
  function automatic int rev(input int k);
    int v;
    int r;
    v = k;
    r = 0;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // floor((v + N/2) / N) when scaling is built in, identity otherwise.
  function automatic int mscale(input int v);
`ifdef FFT_OUT_SCALE_EN
    int s;
    int q;
    s = v + N / 2;
    q = s / N;
    if (s < 0 && (s % N) != 0) q = q - 1;
    return q;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit rdy;
    if (!checking) return;
    rdy = enable && (!m_stream || (m_ptr == N-1 && out_ready));
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_stream});
    if (m_stream) begin
      chk("out_re", $signed(out_re), m_re[m_ptr]);
      chk("out_im", $signed(out_im), m_im[m_ptr]);
      chk("out_idx", {28'b0, out_idx}, m_ptr);
      chk("out_last", {31'b0, out_last}, (m_ptr == N-1) ? 1 : 0);
    end else if (m_zero) begin
      chk("zero_re", $signed(out_re), 0);
      chk("zero_im", $signed(out_im), 0);
      chk("zero_idx", {28'b0, out_idx}, 0);
      chk("zero_last", {31'b0, out_last}, 0);
    end
  endtask

  task automatic model_update();
    bit rdy;
    m_acc = 1'b0;
    if (!rst_n) begin
      m_stream = 1'b0;
      m_ptr    = 0;
      m_zero   = 1'b1;
      checking = 1'b1;
    end else if (enable) begin
      rdy = !m_stream || (m_ptr == N-1 && out_ready);
      if (in_valid && rdy) begin
        for (int k = 0; k < N; k++) begin
          m_re[rev(k)] = mscale(int'($signed(in_re[k*DW +: DW])));
          m_im[rev(k)] = mscale(int'($signed(in_im[k*DW +: DW])));
        end
        m_stream = 1'b1;
        m_ptr    = 0;
        m_zero   = 1'b0;
        m_acc    = 1'b1;
      end else if (m_stream && out_ready) begin
        if (m_ptr == N-1) m_stream = 1'b0;
        else m_ptr = m_ptr + 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (out_valid && out_ready && enable) begin
      obs_re.push_back(int'($signed(out_re)));
      obs_idx.push_back(int'(out_idx));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N; k++) begin
      in_re[k*DW +: DW] = DW'($urandom);
      in_im[k*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic ramp_frame();
    for (int k = 0; k < N; k++) begin
      in_re[k*DW +: DW] = DW'(k);
      in_im[k*DW +: DW] = DW'(-k);
    end
  endtask

  initial begin
    int  cyc;
    int  drops;
    bit  held;
    rst_n     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_re     = '0;
    in_im     = '0;
    checking  = 1'b0;
    m_stream  = 1'b0;
    m_ptr     = 0;
    m_zero    = 1'b1;
    m_acc     = 1'b0;

    // Reset for two cycles.
    step();
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_re", $signed(out_re), 0);
    chk("rst_out_im", $signed(out_im), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);

    // Ramp frame, free-running sink.
    obs_re.delete();
    obs_idx.delete();
    ramp_frame();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (18) step();
    chk("ramp_count", obs_re.size(), N);
    for (int i = 0; i < N; i++) begin
      chk("ramp_seq_re", obs_re[i], mscale(tbl[i]));
      chk("ramp_seq_idx", obs_idx[i], i);
    end

    // Stall the sink for three cycles at bin 5.
    obs_re.delete();
    obs_idx.delete();
    ramp_frame();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    held = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (m_stream && m_ptr == 5 && !held) begin
        held      = 1'b1;
        out_ready = 1'b0;
        repeat (3) begin
          step();
          chk("stall_idx", {28'b0, out_idx}, 5);
          chk("stall_re", $signed(out_re), mscale(10));
        end
        out_ready = 1'b1;
      end
      step();
    end
    chk("stall_seen", {31'b0, held}, 1);
    chk("stall_count", obs_re.size(), N);
    for (int i = 0; i < N; i++) begin
      chk("stall_seq_idx", obs_idx[i], i);
    end

    // Back-to-back frames with the second frame held valid.
    rand_frame();
    in_valid = 1'b1;
    step();
    rand_frame();
    cyc   = 0;
    drops = 0;
    for (int c = 0; c < N + 4; c++) begin
      step();
      cyc++;
      if (!out_valid) drops++;
      if (m_acc) break;
    end
    in_valid = 1'b0;
    chk("b2b_accept_cycles", cyc, N);
    for (int c = 0; c < N; c++) begin
      if (!out_valid) drops++;
      step();
    end
    chk("b2b_no_gap", drops, 0);
    repeat (4) step();

    // Reset mid-frame, then hold enable low.
    rand_frame();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (m_stream && m_ptr == 7) break;
      step();
    end
    chk("mid_idx_reached", {28'b0, out_idx}, 7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    enable   = 1'b0;
    in_valid = 1'b1;
    rand_frame();
    repeat (4) begin
      step();
      chk("dis_in_ready", {31'b0, in_ready}, 0);
      chk("dis_valid", {31'b0, out_valid}, 0);
    end
    enable   = 1'b1;
    in_valid = 1'b0;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (N + 4) step();

    // Rounding frame.
    obs_re.delete();
    obs_idx.delete();
    in_re = '0;
    in_im = '0;
    in_re[0*DW +: DW] = DW'(24);
    in_re[8*DW +: DW] = DW'(-24);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (18) step();
    chk("round_count", obs_re.size(), N);
`ifdef FFT_OUT_SCALE_EN
    chk("round_bin0", obs_re[0], 2);
    chk("round_bin1", obs_re[1], -1);
`else
    chk("round_bin0", obs_re[0], 24);
    chk("round_bin1", obs_re[1], -24);
`endif

    // Random traffic with occasional stalls, freezes and resets.
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || m_acc) begin
        in_valid = ($urandom % 3) != 0;
        if (in_valid) rand_frame();
      end
      out_ready = ($urandom % 4) != 0;
      enable    = ($urandom % 8) != 0;
      rst_n     = ($urandom % 150) != 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
